// File: rtl/uop_feeder.sv
// uop_feeder: per-thread micro-op buffer between decoder and scheduler
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     flush_i           synchronous clear of buffer and issue history
//     wr_valid_i        decoder offers wr_uop_i/wr_last_i; wr_ready_o = ~full
//     consume_i         scheduler issued the head uop this cycle
//     uop_valid_o       head present; uop_next_o/uop_is_last_o describe it
//     uop_last_o        most recently consumed uop (IDLE_UOP after reset/flush)
//     inst_avail_o      at least one complete instruction buffered
//     level_o           entries held
module uop_feeder #(
   parameter int               DEPTH    = 8,
   parameter int               UOP_W    = 20,
   parameter logic [UOP_W-1:0] IDLE_UOP = 20'h00F00
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush_i,
   input  logic                       wr_valid_i,
   input  logic [UOP_W-1:0]           wr_uop_i,
   input  logic                       wr_last_i,
   output logic                       wr_ready_o,
   input  logic                       consume_i,
   output logic                       uop_valid_o,
   output logic [UOP_W-1:0]           uop_next_o,
   output logic                       uop_is_last_o,
   output logic [UOP_W-1:0]           uop_last_o,
   output logic                       inst_avail_o,
   output logic [$clog2(DEPTH+1)-1:0] level_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);
   logic [UOP_W:0]     mem_q [DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]      level_q, level_d, cnt_q, cnt_d;
   logic [UOP_W-1:0]   uop_last_q, uop_last_d;
   logic [UOP_W:0]     head;
   logic               full, empty, push, pop;
   // Extra pointer bit separates full (MSBs differ) from empty (equal)
   assign empty = wr_ptr_q == rd_ptr_q;
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push  = wr_valid_i & ~full;
   assign pop   = consume_i & ~empty;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];
   assign wr_ready_o    = ~full;
   assign uop_valid_o   = ~empty;
   assign uop_next_o    = empty ? IDLE_UOP : head[UOP_W-1:0];
   assign uop_is_last_o = ~empty & head[UOP_W];
   assign uop_last_o    = uop_last_q;
   assign inst_avail_o  = cnt_q != '0;
   assign level_o       = level_q;
   always_comb begin
      wr_ptr_d   = flush_i ? '0 : wr_ptr_q + (AW+1)'(push);
      rd_ptr_d   = flush_i ? '0 : rd_ptr_q + (AW+1)'(pop);
      level_d    = flush_i ? '0 : level_q + LW'(push) - LW'(pop);
      cnt_d      = flush_i ? '0 : cnt_q + LW'(push & wr_last_i) - LW'(pop & head[UOP_W]);
      uop_last_d = flush_i ? IDLE_UOP : pop ? head[UOP_W-1:0] : uop_last_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         cnt_q      <= '0;
         uop_last_q <= IDLE_UOP;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         cnt_q      <= cnt_d;
         uop_last_q <= uop_last_d;
      end
   end
   // Storage is not reset; a flushed push is simply never made visible
   always_ff @(posedge clk) begin
      if (push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= {wr_last_i, wr_uop_i};
   end
endmodule

// File: tb/tb_uop_feeder.sv
// tb_uop_feeder: directed self-checking bench for uop_feeder
module tb_uop_feeder;
   logic        clk = 0, rst_n = 0, flush = 0, wr_valid = 0, wr_last = 0, consume = 0;
   logic [19:0] wr_uop = '0;
   logic        wr_ready, uop_valid, uop_is_last, inst_avail;
   logic [19:0] uop_next, uop_last;
   logic [3:0]  level;
   int          checks = 0, errors = 0;

   uop_feeder dut (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .wr_valid_i(wr_valid), .wr_uop_i(wr_uop), .wr_last_i(wr_last), .wr_ready_o(wr_ready),
      .consume_i(consume), .uop_valid_o(uop_valid), .uop_next_o(uop_next),
      .uop_is_last_o(uop_is_last), .uop_last_o(uop_last), .inst_avail_o(inst_avail), .level_o(level)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [19:0] u, input logic l);
      wr_valid = 1; wr_uop = u; wr_last = l;
      tick();
      wr_valid = 0; wr_last = 0;
   endtask

   task automatic pop();
      consume = 1;
      tick();
      consume = 0;
   endtask

   initial begin
      tick(); tick();
      rst_n = 1;
      tick();
      // Reset asserted mid-stream
      push(20'h0AAAA, 0);
      push(20'h0BBBB, 1);
      pop();
      chk("pre_rst_last", uop_last, 20'h0AAAA);
      chk("pre_rst_level", level, 1);
      #2 rst_n = 0;
      #1;
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_uop_valid", uop_valid, 0);
      chk("rst_uop_next", uop_next, 20'h00F00);
      chk("rst_uop_last", uop_last, 20'h00F00);
      chk("rst_level", level, 0);
      chk("rst_is_last", uop_is_last, 0);
      chk("rst_inst_avail", inst_avail, 0);
      tick();
      rst_n = 1;
      tick();
      // Three-uop instruction
      wr_valid = 1; wr_uop = 20'h01203; wr_last = 0;
      #1 chk("no_bypass_valid", uop_valid, 0);
      chk("no_bypass_next", uop_next, 20'h00F00);
      tick(); wr_valid = 0;
      chk("i1_avail", inst_avail, 0);
      chk("i1_next", uop_next, 20'h01203);
      push(20'h02210, 0);
      chk("i2_avail", inst_avail, 0);
      push(20'h03340, 1);
      chk("i3_avail", inst_avail, 1);
      chk("i3_level", level, 3);
      chk("i3_is_last", uop_is_last, 0);
      pop();
      chk("c1_last", uop_last, 20'h01203);
      chk("c1_next", uop_next, 20'h02210);
      pop();
      chk("c2_next", uop_next, 20'h03340);
      chk("c2_is_last", uop_is_last, 1);
      chk("c2_avail", inst_avail, 1);
      pop();
      chk("c3_last", uop_last, 20'h03340);
      chk("c3_avail", inst_avail, 0);
      chk("c3_level", level, 0);
      chk("c3_valid", uop_valid, 0);
      // Fill to full
      for (int i = 0; i < 8; i++) push(20'h10000 + 20'(i), i == 7);
      chk("full_ready", wr_ready, 0);
      chk("full_level", level, 8);
      chk("full_avail", inst_avail, 1);
      wr_valid = 1; wr_uop = 20'h1FFFF; consume = 1;
      tick();
      wr_valid = 0; consume = 0;
      chk("fullpp_level", level, 7);
      chk("fullpp_last", uop_last, 20'h10000);
      chk("fullpp_ready", wr_ready, 1);
      for (int i = 1; i < 8; i++) begin
         chk("drain_next", uop_next, 20'h10000 + 20'(i));
         pop();
      end
      chk("drain_valid", uop_valid, 0);
      chk("drain_avail", inst_avail, 0);
      chk("drain_last", uop_last, 20'h10007);
      // Steady push+consume across pointer wrap
      push(20'h20000, 0);
      push(20'h20001, 0);
      for (int i = 0; i < 20; i++) begin
         wr_valid = 1; wr_uop = 20'h20002 + 20'(i); consume = 1;
         tick();
         chk("steady_last", uop_last, 20'h20000 + 20'(i));
         chk("steady_level", level, 2);
      end
      wr_valid = 0; consume = 0;
      chk("steady_head", uop_next, 20'h20014);
      pop(); pop();
      chk("steady_end_last", uop_last, 20'h20015);
      // Consume while empty
      pop();
      chk("empty_pop_last", uop_last, 20'h20015);
      chk("empty_pop_level", level, 0);
      // Flush with concurrent push and pop
      for (int i = 0; i < 5; i++) push(20'h30000 + 20'(i), 1);
      chk("preflush_level", level, 5);
      flush = 1; wr_valid = 1; wr_uop = 20'h3FFFF; wr_last = 1; consume = 1;
      tick();
      flush = 0; wr_valid = 0; wr_last = 0; consume = 0;
      chk("flush_level", level, 0);
      chk("flush_last", uop_last, 20'h00F00);
      chk("flush_avail", inst_avail, 0);
      tick();
      chk("flush_valid", uop_valid, 0);
      chk("flush_next", uop_next, 20'h00F00);
      // Store flag propagation
      push(20'h02000, 1);
      chk("st_pre_last", uop_last, 20'h00F00);
      pop();
      chk("st_flag", uop_last[13], 1);
      chk("st_last", uop_last, 20'h02000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
